// File: rtl/prbs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prbs_pkg : polynomial codes, order/tap tables and mask helper for PRBS.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package prbs_pkg;

  localparam int LFSR_W = 31;

  typedef logic [LFSR_W-1:0] lfsr_t;

  localparam logic [2:0] PRBS7  = 3'd0;
  localparam logic [2:0] PRBS9  = 3'd1;
  localparam logic [2:0] PRBS15 = 3'd2;
  localparam logic [2:0] PRBS23 = 3'd3;
  localparam logic [2:0] PRBS31 = 3'd4;

  // Codes 5..7 are not polynomials of their own; they fall back to PRBS7.
  function automatic logic [2:0] poly_map(input logic [2:0] sel);
    logic [2:0] code;
    code = (sel > PRBS31) ? PRBS7 : sel;
    return code;
  endfunction

  function automatic logic [4:0] poly_order(input logic [2:0] code);
    logic [4:0] n;
    case (code)
      PRBS9:   n = 5'd9;
      PRBS15:  n = 5'd15;
      PRBS23:  n = 5'd23;
      PRBS31:  n = 5'd31;
      default: n = 5'd7;
    endcase
    return n;
  endfunction

  function automatic logic [4:0] poly_tap(input logic [2:0] code);
    logic [4:0] t;
    case (code)
      PRBS9:   t = 5'd4;
      PRBS15:  t = 5'd13;
      PRBS23:  t = 5'd17;
      PRBS31:  t = 5'd27;
      default: t = 5'd5;
    endcase
    return t;
  endfunction

  function automatic lfsr_t poly_mask(input logic [2:0] code);
    logic [31:0] m;
    m = (32'd1 << poly_order(code)) - 32'd1;
    return m[LFSR_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_gen_param_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prbs_gen_param_if : control + valid/ready output bundle of the PRBS gen. |
// | PRBS_ERR_INJ_EN adds err_inject / err_cnt.        Revision : 1.0         |
// +--------------------------------------------------------------------------+
interface prbs_gen_param_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
);
  logic              en;
  logic [2:0]        poly_sel;
  logic              seed_load;
  logic [30:0]       seed;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  word_cnt;
  logic [2:0]        poly_act;
`ifdef PRBS_ERR_INJ_EN
  logic              err_inject;
  logic [15:0]       err_cnt;

  modport master (
    input  en, poly_sel, seed_load, seed, out_ready, err_inject,
    output out_valid, out_data, word_cnt, poly_act, err_cnt
  );
  modport slave (
    output en, poly_sel, seed_load, seed, out_ready, err_inject,
    input  out_valid, out_data, word_cnt, poly_act, err_cnt
  );
`else
  modport master (
    input  en, poly_sel, seed_load, seed, out_ready,
    output out_valid, out_data, word_cnt, poly_act
  );
  modport slave (
    output en, poly_sel, seed_load, seed, out_ready,
    input  out_valid, out_data, word_cnt, poly_act
  );
`endif
endinterface
`default_nettype wire

// File: rtl/prbs_lfsr_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prbs_lfsr_core : combinational DATA_W-step advance of the shared LFSR.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module prbs_lfsr_core
  import prbs_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  lfsr_t             i_state,
  input  logic [2:0]        i_poly,
  output logic [DATA_W-1:0] o_word,
  output lfsr_t             o_next_state
);

  lfsr_t      w_mask;
  logic [4:0] w_msb;
  logic [4:0] w_tap;

  assign w_mask = poly_mask(i_poly);
  assign w_msb  = poly_order(i_poly) - 5'd1;
  assign w_tap  = poly_tap(i_poly);

  // Each output bit is the MSB right after its shift; bits above the order stay zero.
  always_comb begin : comb_advance
    lfsr_t w_s;
    logic  w_f;
    w_s    = i_state & w_mask;
    w_f    = 1'b0;
    o_word = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_f       = w_s[w_msb] ^ w_s[w_tap];
      w_s       = {w_s[LFSR_W-2:0], w_f} & w_mask;
      o_word[i] = w_s[w_msb];
    end
    o_next_state = w_s;
  end

endmodule
`default_nettype wire

// File: rtl/prbs_gen_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prbs_gen_param : multi-polynomial PRBS word generator, valid/ready out.  |
// | Optional macro PRBS_ERR_INJ_EN adds single-bit error injection.  Rev 1.0 |
// +--------------------------------------------------------------------------+
module prbs_gen_param
  import prbs_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  prbs_gen_param_if.master bus
);

  lfsr_t             r_state;
  logic [2:0]        r_poly;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_word_out;
  lfsr_t             w_next;
  logic [2:0]        w_sel;
  lfsr_t             w_seed_masked;
  lfsr_t             w_seed_state;
  logic              w_load;
  logic              w_accept;

  prbs_lfsr_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .i_state      (r_state),
    .i_poly       (r_poly),
    .o_word       (w_word),
    .o_next_state (w_next)
  );

  assign w_sel         = poly_map(bus.poly_sel);
  assign w_seed_masked = bus.seed & poly_mask(w_sel);
  // All-zero is the LFSR lock-up state, so a zero seed restarts from 1.
  assign w_seed_state  = (w_seed_masked == '0) ? lfsr_t'(1) : w_seed_masked;

  assign w_load   = bus.en && (!r_valid || bus.out_ready) && !bus.seed_load;
  assign w_accept = r_valid && bus.out_ready;

`ifdef PRBS_ERR_INJ_EN
  logic        r_err_pend;
  logic [15:0] r_err_cnt;

  // Injection flips only the emitted bit; the LFSR keeps running clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_pend <= 1'b0;
      r_err_cnt  <= 16'd0;
    end else begin
      r_err_pend <= bus.err_inject | (r_err_pend & ~w_load);
      if (w_load && r_err_pend && (r_err_cnt != 16'hFFFF))
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign w_word_out  = w_word ^ DATA_W'(r_err_pend);
  assign bus.err_cnt = r_err_cnt;
`else
  assign w_word_out  = w_word;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= lfsr_t'(1);
      r_poly  <= PRBS7;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_accept)
        r_cnt <= r_cnt + CNT_W'(1);
      if (bus.seed_load) begin
        r_state <= w_seed_state;
        r_poly  <= w_sel;
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_data  <= w_word_out;
        r_state <= w_next;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.word_cnt  = r_cnt;
  assign bus.poly_act  = r_poly;

endmodule
`default_nettype wire

// File: tb/tb_prbs_gen_param.sv
`default_nettype none
// Bench for prbs_gen_param: bit-history reference model feeding a word scoreboard.
module tb_prbs_gen_param;

  logic clk;
  logic rst_n;

  prbs_gen_param_if #(.DATA_W(64), .CNT_W(32)) bus ();

  prbs_gen_param #(.DATA_W(64), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] q[$];
  logic [63:0] cap[$];
  logic        exp_valid;
  logic [31:0] exp_cnt;
  logic [2:0]  exp_poly;
  bit          fq[$];
  int          m_n;
  int          m_t;
`ifdef PRBS_ERR_INJ_EN
  logic        drv_inj;
  logic        exp_err_pend;
  logic [15:0] exp_err_cnt;
`endif

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference keeps the feedback-bit history: f[k] = f[k-N] ^ f[k-1-t], out[k] = f[k-N+1].
  function automatic void model_seed(input logic [2:0] code, input logic [30:0] sd);
    logic [30:0] mk;
    case (code)
      3'd1:    begin m_n = 9;  m_t = 4;  end
      3'd2:    begin m_n = 15; m_t = 13; end
      3'd3:    begin m_n = 23; m_t = 17; end
      3'd4:    begin m_n = 31; m_t = 27; end
      default: begin m_n = 7;  m_t = 5;  end
    endcase
    mk = 31'h0;
    for (int p = 0; p < m_n; p++) mk[p] = sd[p];
    if (mk == 31'h0) mk = 31'h1;
    fq.delete();
    for (int p = m_n - 1; p >= 0; p--) fq.push_back(mk[p]);
  endfunction

  function automatic logic [63:0] model_next_word();
    logic [63:0] w;
    bit          f;
    for (int i = 0; i < 64; i++) begin
      f = fq[fq.size() - m_n] ^ fq[fq.size() - 1 - m_t];
      fq.push_back(f);
      w[i] = fq[fq.size() - m_n];
    end
    while (fq.size() > 40) void'(fq.pop_front());
    return w;
  endfunction

  function automatic void model_reset();
    q.delete();
    exp_valid = 1'b0;
    exp_cnt   = 32'd0;
    exp_poly  = 3'd0;
    model_seed(3'd0, 31'd1);
`ifdef PRBS_ERR_INJ_EN
    exp_err_pend = 1'b0;
    exp_err_cnt  = 16'd0;
`endif
  endfunction

  task automatic check_reset_values();
    check("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
    check("rst_out_data",  {64'd0, bus.out_data},   128'd0);
    check("rst_word_cnt",  {96'd0, bus.word_cnt},   128'd0);
    check("rst_poly_act",  {125'd0, bus.poly_act},  128'd0);
`ifdef PRBS_ERR_INJ_EN
    check("rst_err_cnt",   {112'd0, bus.err_cnt},   128'd0);
`endif
  endtask

  // One clock: drive at posedge+1, check at negedge, then advance the scoreboard.
  task automatic step(input logic en_, input logic rdy, input logic sl,
                      input logic [2:0] ps, input logic [30:0] sd);
    logic        acc;
    logic        ld;
    logic [63:0] w;
    bus.en        = en_;
    bus.out_ready = rdy;
    bus.seed_load = sl;
    bus.poly_sel  = ps;
    bus.seed      = sd;
`ifdef PRBS_ERR_INJ_EN
    bus.err_inject = drv_inj;
`endif
    @(negedge clk);
    check("out_valid", {127'd0, bus.out_valid}, {127'd0, exp_valid});
    if (exp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard_empty: observed=%0h expected=<none>", bus.out_data);
      end else begin
        check("out_data", {64'd0, bus.out_data}, {64'd0, q[0]});
      end
    end
    check("word_cnt", {96'd0, bus.word_cnt}, {96'd0, exp_cnt});
    check("poly_act", {125'd0, bus.poly_act}, {125'd0, exp_poly});
`ifdef PRBS_ERR_INJ_EN
    check("err_cnt", {112'd0, bus.err_cnt}, {112'd0, exp_err_cnt});
`endif
    acc = exp_valid && rdy;
    ld  = en_ && (!exp_valid || rdy) && !sl;
    if (acc) begin
      cap.push_back(bus.out_data);
      if (q.size() > 0) void'(q.pop_front());
      exp_cnt = exp_cnt + 32'd1;
    end
    if (sl) begin
      if (exp_valid && !acc && q.size() > 0) void'(q.pop_front());
      exp_valid = 1'b0;
      exp_poly  = (ps > 3'd4) ? 3'd0 : ps;
      model_seed(exp_poly, sd);
    end else if (ld) begin
      w = model_next_word();
`ifdef PRBS_ERR_INJ_EN
      if (exp_err_pend) begin
        w[0]        = ~w[0];
        exp_err_cnt = exp_err_cnt + 16'd1;
      end
`endif
      q.push_back(w);
      exp_valid = 1'b1;
    end else if (acc) begin
      exp_valid = 1'b0;
    end
`ifdef PRBS_ERR_INJ_EN
    exp_err_pend = drv_inj | (exp_err_pend & ~ld);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.out_ready = 1'b0;
    bus.seed_load = 1'b0;
    bus.poly_sel  = 3'd0;
    bus.seed      = 31'd0;
`ifdef PRBS_ERR_INJ_EN
    drv_inj        = 1'b0;
    bus.err_inject = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // PRBS7 from the reset seed: first word pattern and 127-word periodicity.
    cap.delete();
    repeat (301) step(1'b1, 1'b1, 1'b0, 3'd0, 31'd0);
    if (cap.size() > 0) check("prbs7_first_bits", {121'd0, cap[0][6:0]}, {121'd0, 7'b0100000});
    for (int k = 0; k + 127 < cap.size(); k++)
      check("prbs7_period", {64'd0, cap[k + 127]}, {64'd0, cap[k]});

    // Backpressure for five cycles mid-stream.
    repeat (3)  step(1'b1, 1'b1, 1'b0, 3'd0, 31'd0);
    repeat (5)  step(1'b1, 1'b0, 1'b0, 3'd0, 31'd0);
    repeat (10) step(1'b1, 1'b1, 1'b0, 3'd0, 31'd0);

    // poly_sel without seed_load is ignored; then switch to PRBS15.
    repeat (4)  step(1'b1, 1'b1, 1'b0, 3'd2, 31'd0);
    step(1'b1, 1'b1, 1'b1, 3'd2, 31'h7FFF);
    repeat (41) step(1'b1, 1'b1, 1'b0, 3'd2, 31'd0);
    step(1'b0, 1'b1, 1'b0, 3'd2, 31'd0);

    // PRBS31 with a zero seed.
    step(1'b0, 1'b1, 1'b1, 3'd4, 31'd0);
    cap.delete();
    repeat (1001) step(1'b1, 1'b1, 1'b0, 3'd4, 31'd0);
    if (cap.size() > 0) check("prbs31_first_bits", {97'd0, cap[0][30:0]}, {97'd0, 31'h2000_0000});
    for (int k = 0; k < cap.size(); k++)
      check("prbs31_nonzero", {127'd0, (cap[k] != 64'd0)}, 128'd1);

    // en dropped while a word is stalled: held, then accepted, then valid falls.
    step(1'b1, 1'b0, 1'b0, 3'd4, 31'd0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 3'd4, 31'd0);
    step(1'b0, 1'b1, 1'b0, 3'd4, 31'd0);
    step(1'b0, 1'b1, 1'b0, 3'd4, 31'd0);

    // Seed load discards a stalled word; code 7 maps to PRBS7.
    repeat (3)  step(1'b1, 1'b1, 1'b0, 3'd4, 31'd0);
    step(1'b1, 1'b0, 1'b1, 3'd7, 31'h55);
    repeat (21) step(1'b1, 1'b1, 1'b0, 3'd7, 31'd0);
    step(1'b0, 1'b1, 1'b0, 3'd7, 31'd0);

`ifdef PRBS_ERR_INJ_EN
    // Two pulses before a load yield a single inverted bit 0.
    drv_inj = 1'b1;
    repeat (2) step(1'b0, 1'b1, 1'b0, 3'd0, 31'd0);
    drv_inj = 1'b0;
    repeat (11) step(1'b1, 1'b1, 1'b0, 3'd0, 31'd0);
    check("err_cnt_total", {112'd0, bus.err_cnt}, 128'd1);
`endif

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) step(1'b1, 1'b1, 1'b0, 3'd0, 31'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
